dec_ex_pipe_stage: RTL and testbench

Parametrised, elastic decode-to-execute pipeline register. It replaces the fixed single-entry DEC/EX latch with a two-entry skid buffer that uses a valid/ready handshake.
- Adds stall back-pressure without a combinational ready path.
- Flush inserts bubbles.
- Control bits are forced to zero on bubbles, so an invalid slot never writes the register file or memory.
- Sits between the decode stage and the ALU/execute stage.

---
 rtl/dec_ex_pipe_stage.sv | 178 +++++++++++++++++
 tb/tb_dec_ex_pipe_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_ex_pipe_stage.sv
// Purpose : elastic decode-to-execute pipeline register (two-entry skid buffer, valid/ready).
// Latency : 1 cycle from an accept in EMPTY to the outputs; FIFO order, no reordering.
// Backpr. : in_ready is a flop (state != TWO after the edge); no combinational out_ready->in_ready path.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-low reset
//   flush             - drop every held entry and the same-cycle input
//   in_valid/in_ready - decode-side handshake; in_data/in_regs/in_ctrl carry the instruction
//   out_valid/out_ready - execute-side handshake; out_data/out_regs/out_ctrl show the head entry
//   stall_cnt, flush_cnt - saturating event counters, present only with DEC_PIPE_STATS_EN defined
//
// Build option: define DEC_PIPE_STATS_EN to add the stall/flush counters.
module dec_ex_pipe_stage #(
  parameter int DBITS               = 32,
  parameter int NUM_WORDS           = 5,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int CTRL_W              = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_WORDS*DBITS-1:0]       in_data,
  input  logic [3*REG_INDEX_BIT_WIDTH-1:0] in_regs,
  input  logic [CTRL_W-1:0]                in_ctrl,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_WORDS*DBITS-1:0]       out_data,
  output logic [3*REG_INDEX_BIT_WIDTH-1:0] out_regs,
  output logic [CTRL_W-1:0]                out_ctrl
`ifdef DEC_PIPE_STATS_EN
  ,
  output logic [15:0]                      stall_cnt,
  output logic [15:0]                      flush_cnt
`endif
);

  localparam int DW = NUM_WORDS * DBITS;
  localparam int RW = 3 * REG_INDEX_BIT_WIDTH;

  // One buffered instruction: data words, register indices, control word.
  typedef struct packed {
    logic [DW-1:0]     dat;
    logic [RW-1:0]     regs;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_in_ready;
  entry_t r_main;   // head entry, drives the outputs
  entry_t r_skid;   // younger entry, only meaningful in ST_TWO
  entry_t w_in_entry;

  logic w_accept;
  logic w_retire;
  logic w_ld_main_in;    // main <= input
  logic w_ld_main_skid;  // main <= skid (skid drains forward)
  logic w_ld_skid;       // skid <= input

  assign w_in_entry = '{dat: in_data, regs: in_regs, ctrl: in_ctrl};

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = r_in_ready;
  assign w_accept  = in_valid && r_in_ready;
  assign w_retire  = out_valid && out_ready;

  // Next-state and load-enable decode. Flush wins over any accept; a retire
  // in the same cycle is simply consumed, nothing needs to be loaded for it.
  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_retire) begin
            // Head leaves and the new instruction takes its place: no bubble.
            w_ld_main_in = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_TWO;
            w_ld_skid   = 1'b1;
          end else if (w_retire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a retire can move the state.
          if (w_retire) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered from the next state so the upstream sees the post-edge
      // occupancy without any combinational dependency on out_ready.
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main <= w_in_entry;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  assign out_data = r_main.dat;
  assign out_regs = r_main.regs;
  // Bubbles must never carry write enables into execute.
  assign out_ctrl = out_valid ? r_main.ctrl : '0;

`ifdef DEC_PIPE_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      // Only flushes that actually kill something are counted.
      if (flush && (r_state != ST_EMPTY) && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

`ifndef SYNTHESIS
  a_bubble_ctrl_zero: assert property (@(posedge clk) disable iff (!reset)
    (!out_valid |-> (out_ctrl == '0)));
`endif

endmodule

// File: tb/tb_dec_ex_pipe_stage.sv
// Purpose : self-checking bench for dec_ex_pipe_stage (directed test-plan sequences plus random traffic).
// Latency : n/a (bench).
// Backpr. : random out_ready drives stalls; expected instruction stream kept in a queue.
module tb_dec_ex_pipe_stage;

  localparam int DW = 160;
  localparam int RW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [RW-1:0] in_regs;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_regs;
  logic [CW-1:0] out_ctrl;
`ifdef DEC_PIPE_STATS_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  always #5 clk = ~clk;

  dec_ex_pipe_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_regs   (in_regs),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_regs  (out_regs),
    .out_ctrl  (out_ctrl)
`ifdef DEC_PIPE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
  } ent_t;

  ent_t exp_q[$];   // accepted instructions, oldest first
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: how many instructions the stage holds this cycle.
  int   held      = 0;
  logic exp_rdy   = 1'b0;
  logic after_rst = 1'b0;
  logic mon_en    = 1'b0;
  int   stall_m   = 0;
  int   flush_m   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one cycle of stimulus; record the instruction if it will be accepted.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [RW-1:0] r,
                       input logic [CW-1:0] c, input logic ordy, input logic fl, input logic rst);
    ent_t e;
    in_valid  = v;
    in_data   = d;
    in_regs   = r;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    if (v && (in_ready === 1'b1) && !fl && rst) begin
      e.d = d; e.r = r; e.c = c;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: checks the visible cycle, then advances the model across the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", DW'(in_ready), DW'(exp_rdy));
      chk("out_valid", DW'(out_valid), DW'(held > 0));
      if (held == 0) chk("bubble_ctrl", DW'(out_ctrl), '0);
      if (after_rst) begin
        chk("rst_data", out_data, '0);
        chk("rst_regs", DW'(out_regs), '0);
      end
`ifdef DEC_PIPE_STATS_EN
      chk("stall_cnt", DW'(stall_cnt), DW'(stall_m));
      chk("flush_cnt", DW'(flush_cnt), DW'(flush_m));
`endif
      if (held > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL head_missing: got valid output expected nothing queued");
        end else begin
          chk("head_data", out_data, exp_q[0].d);
          chk("head_regs", DW'(out_regs), DW'(exp_q[0].r));
          chk("head_ctrl", DW'(out_ctrl), DW'(exp_q[0].c));
        end
      end
      if (!reset) begin
        held = 0; exp_q.delete(); exp_rdy = 1'b0; after_rst = 1'b1;
        stall_m = 0; flush_m = 0;
      end else begin
        if (held > 0 && !out_ready && stall_m < 65535) stall_m++;
        if (held > 0 && flush && flush_m < 65535) flush_m++;
        if (held > 0 && out_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          held--;
        end
        if (flush) begin
          held = 0; exp_q.delete();
        end else if (in_valid && exp_rdy) begin
          held++;
        end
        exp_rdy   = (held < 2);
        after_rst = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] d0;
    in_valid = 0; in_data = '0; in_regs = '0; in_ctrl = '0;
    out_ready = 0; flush = 0; reset = 0;
    @(posedge clk); #2;
    // First reset edge has happened: outputs are defined from here on.
    mon_en = 1'b1; after_rst = 1'b1;
    drive(0, '0, '0, '0, 1, 0, 0);
    drive(0, '0, '0, '0, 1, 0, 1);   // first cycle after deassert: in_ready rises

    // Reset then stream: the test-plan instruction, then idle.
    d0 = '0;
    d0[31:0]  = 32'hFFFF_FFFF;
    d0[63:32] = 32'hFFFF_FFFE;
    chk("rdy_after_reset", DW'(in_ready), 1);
    drive(1, d0, {4'd2, 4'd5, 4'd3}, 8'h35, 1, 0, 1);
    chk("stream_valid", DW'(out_valid), 1);
    chk("stream_ctrl", DW'(out_ctrl), DW'(8'h35));
    chk("stream_rdy", DW'(in_ready), 1);
    drive(0, '0, '0, '0, 1, 0, 1);

    // Stall fill: A then B with execute stalled.
    drive(1, rnd_data(), 12'h111, 8'h01, 0, 0, 1);
    drive(1, rnd_data(), 12'h222, 8'h02, 0, 0, 1);
    chk("fill_rdy_low", DW'(in_ready), 0);
    chk("fill_head_ctrl", DW'(out_ctrl), DW'(8'h01));
    drive(1, rnd_data(), 12'h333, 8'h03, 0, 0, 1);   // refused: stage full
    chk("fill_hold_ctrl", DW'(out_ctrl), DW'(8'h01));
    drive(0, '0, '0, '0, 1, 0, 1);                   // A retires
    chk("drain_rdy_high", DW'(in_ready), 1);
    chk("drain_b_ctrl", DW'(out_ctrl), DW'(8'h02));
    drive(0, '0, '0, '0, 1, 0, 1);                   // B retires

    // 10 back-to-back with simultaneous accept and retire.
    for (int i = 0; i < 10; i++) begin
      drive(1, rnd_data(), RW'($urandom), CW'(i + 16), 1, 0, 1);
      chk("b2b_valid", DW'(out_valid), 1);
    end
    drive(0, '0, '0, '0, 1, 0, 1);

    // Flush in TWO with in_valid high.
    drive(1, rnd_data(), 12'h0a1, 8'h41, 0, 0, 1);
    drive(1, rnd_data(), 12'h0a2, 8'h42, 0, 0, 1);
    drive(1, rnd_data(), 12'h0a3, 8'h43, 0, 1, 1);
    chk("flush_valid", DW'(out_valid), 0);
    chk("flush_ctrl", DW'(out_ctrl), 0);
    chk("flush_rdy", DW'(in_ready), 1);
    drive(0, '0, '0, '0, 1, 0, 1);

    // Mid-operation reset in TWO.
    drive(1, rnd_data(), 12'h0b1, 8'h51, 0, 0, 1);
    drive(1, rnd_data(), 12'h0b2, 8'h52, 0, 0, 1);
    drive(0, '0, '0, '0, 1, 0, 0);
    chk("mrst_valid", DW'(out_valid), 0);
    chk("mrst_data", out_data, '0);
    drive(0, '0, '0, '0, 1, 0, 1);
    drive(0, '0, '0, '0, 1, 0, 1);

`ifdef DEC_PIPE_STATS_EN
    drive(0, '0, '0, '0, 1, 0, 0);
    drive(0, '0, '0, '0, 1, 0, 1);
    drive(1, rnd_data(), 12'h0c1, 8'h61, 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, '0, '0, '0, 0, 0, 1);
    drive(0, '0, '0, '0, 1, 1, 1);
    chk("stats_stall5", DW'(stall_cnt), 5);
    chk("stats_flush1", DW'(flush_cnt), 1);
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) != 0, rnd_data(), RW'($urandom), CW'($urandom),
            ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 80) != 0);
    end
    for (int i = 0; i < 4; i++) drive(0, '0, '0, '0, 1, 0, 1);
    chk("drained_empty", DW'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
